// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF scheduler:
// default widths, the default reset threshold and the sweep FSM encoding.
package lif_pkg;

  localparam int STATE_W_DEF    = 5;
  localparam int THRESH_RST_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational LIF neuron update.
// Fires when the pre-update state reaches the threshold.
// The next state is current + state/2, wrapping modulo 2^STATE_W.
// Build option LIF_SCHED_RESET_ON_SPIKE_EN: a firing neuron's next state is
// forced to zero (reset-on-fire). Without it the leaky sum is kept even on
// a spike.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_current,
  input  logic [STATE_W-1:0] i_thresh,
  output logic [STATE_W-1:0] o_next_state,
  output logic               o_spk
);

  logic [STATE_W-1:0] w_sum;

  // Spike decision on the old state and the wrapped leaky integration.
  always_comb begin
    o_spk = (i_state >= i_thresh);
    w_sum = i_current + (i_state >> 1);
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
    if (o_spk) begin
      o_next_state = {STATE_W{1'b0}};
    end else begin
      o_next_state = w_sum;
    end
`else
    o_next_state = w_sum;
`endif
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF scheduler.
// A single lif_update_unit is shared across N_NEURONS virtual neurons.
// Each tick sweeps every neuron in turn, one neuron per cycle, starting at
// index 0. Spiking indices leave through a single-entry valid/ready slot.
// When the slot is full and a neuron would fire, the sweep stalls on that
// neuron until the slot is accepted.
// Optional build macro: LIF_SCHED_RESET_ON_SPIKE_EN, handled in lif_update_unit.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = 3,
  parameter int STATE_W    = STATE_W_DEF,
  parameter int THRESH_RST = THRESH_RST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [STATE_W-1:0] cfg_data,
  input  logic               thr_we,
  input  logic               tick,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic [IDX_W-1:0]   spike_idx
);

  fsm_e               r_fsm;
  fsm_e               w_fsm_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [STATE_W-1:0] r_state   [N_NEURONS];
  logic [STATE_W-1:0] r_current [N_NEURONS];
  logic [STATE_W-1:0] r_thresh;
  logic               r_spike_valid;
  logic [IDX_W-1:0]   r_spike_idx;
  logic               r_overrun;

  logic [STATE_W-1:0] w_next_state;
  logic               w_spk;
  logic               w_accept;
  logic               w_upd;
  logic               w_last;
  logic               w_done;

  lif_update_unit #(
    .STATE_W (STATE_W)
  ) u_update (
    .i_state      (r_state[r_idx]),
    .i_current    (r_current[r_idx]),
    .i_thresh     (r_thresh),
    .o_next_state (w_next_state),
    .o_spk        (w_spk)
  );

  // A neuron advances unless it fires into a slot that stays occupied.
  always_comb begin
    w_accept = r_spike_valid & spike_ready;
    w_upd    = (r_fsm == SWEEP) && (!w_spk || !r_spike_valid || w_accept);
    w_last   = (r_idx == IDX_W'(N_NEURONS - 1));
  end

  // Next-state logic; done marks the cycle the FSM leaves DRAIN.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_done    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (tick) begin
          w_fsm_nxt = SWEEP;
        end else begin
          w_fsm_nxt = IDLE;
        end
      end
      SWEEP: begin
        if (w_upd && w_last) begin
          w_fsm_nxt = DRAIN;
        end else begin
          w_fsm_nxt = SWEEP;
        end
      end
      DRAIN: begin
        if (!r_spike_valid) begin
          w_fsm_nxt = IDLE;
          w_done    = 1'b1;
        end else begin
          w_fsm_nxt = DRAIN;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Neuron index counter: advances on each accepted update, back to 0 after the last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_upd) begin
      r_idx <= w_last ? {IDX_W{1'b0}} : r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Membrane state array: only the neuron under update is written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i] <= {STATE_W{1'b0}};
      end
    end else if (w_upd) begin
      r_state[r_idx] <= w_next_state;
    end
  end

  // Input current array; writes to out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_current[i] <= {STATE_W{1'b0}};
      end
    end else if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
      r_current[cfg_addr] <= cfg_data;
    end
  end

  // Firing threshold register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_thresh <= STATE_W'(THRESH_RST);
    end else if (thr_we) begin
      r_thresh <= cfg_data;
    end
  end

  // Single-entry output slot; accept and reload may coincide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_spike_valid <= 1'b0;
      r_spike_idx   <= {IDX_W{1'b0}};
    end else if (w_upd && w_spk) begin
      r_spike_valid <= 1'b1;
      r_spike_idx   <= r_idx;
    end else if (w_accept) begin
      r_spike_valid <= 1'b0;
    end
  end

  // Sticky overrun flag: set by a tick that arrives while a sweep is active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (tick && (r_fsm != IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign busy        = (r_fsm != IDLE);
  assign done        = w_done;
  assign overrun     = r_overrun;
  assign spike_valid = r_spike_valid;
  assign spike_idx   = r_spike_idx;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench for lif_tdm_scheduler.
// A table of single-neuron vectors is followed by hand-written sequences
// covering stalls, overrun, reset mid-sweep and same-cycle config writes.
// The bench honours LIF_SCHED_RESET_ON_SPIKE_EN for its expected states.
module tb_lif_tdm_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_data;
  logic       thr_we;
  logic       tick;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       spike_valid;
  logic       spike_ready;
  logic [2:0] spike_idx;

  int total = 0;
  int bad   = 0;
  int ev [32];

  typedef struct {
    int cur;
    int thr;
    int ticks;
    int exp_ev;
    int exp_st_off;
    int exp_st_on;
  } vec_t;

  vec_t vecs [6];

  lif_tdm_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .thr_we      (thr_we),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_idx   (spike_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_step();
    clk_step();
    reset = 1'b1;
  endtask

  task automatic write_cur(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_data = 5'(data);
    clk_step();
    cfg_we   = 1'b0;
  endtask

  task automatic write_thr(input int data);
    thr_we   = 1'b1;
    cfg_data = 5'(data);
    clk_step();
    thr_we   = 1'b0;
  endtask

  // Record accepted events until done, bounded by a cycle budget.
  task automatic collect(output int n_ev, output int got_done);
    n_ev     = 0;
    got_done = 0;
    for (int k = 0; k < 200; k++) begin
      if (spike_valid && spike_ready) begin
        if (n_ev < 32) ev[n_ev] = int'(spike_idx);
        n_ev++;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      clk_step();
    end
    clk_step();
  endtask

  task automatic run_sweep(output int n_ev, output int got_done);
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    collect(n_ev, got_done);
  endtask

  initial begin
    int n;
    int gd;
    int n_tot;
    int exp_st;
    int done_seen;

    reset = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 5'd0;
    thr_we = 1'b0; tick = 1'b0; spike_ready = 1'b1;

    // cur, thr, ticks, events, state (reset-on-fire off), state (on)
    vecs[0] = '{10, 10, 2,  1, 15,  0};
    vecs[1] = '{ 4,  7, 4,  1,  7,  0};
    vecs[2] = '{31, 31, 3,  1,  6, 31};
    vecs[3] = '{ 0,  0, 2, 16,  0,  0};
    vecs[4] = '{20, 25, 3,  1,  3,  0};
    vecs[5] = '{ 5, 31, 3,  0,  8,  8};

    // Reset values while reset is held.
    clk_step();
    clk_step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_valid", int'(spike_valid), 0);
    chk("rst_idx", int'(spike_idx), 0);
    reset = 1'b1;

    // Table: drive neuron 3 only, run several sweeps, check events and state.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      spike_ready = 1'b1;
      write_cur(3, vecs[v].cur);
      write_thr(vecs[v].thr);
      n_tot = 0;
      for (int t = 0; t < vecs[v].ticks; t++) begin
        run_sweep(n, gd);
        chk($sformatf("vec%0d_done%0d", v, t), gd, 1);
        n_tot += n;
      end
      chk($sformatf("vec%0d_events", v), n_tot, vecs[v].exp_ev);
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
      exp_st = vecs[v].exp_st_on;
`else
      exp_st = vecs[v].exp_st_off;
`endif
      chk($sformatf("vec%0d_state3", v), int'(dut.r_state[3]), exp_st);
      chk($sformatf("vec%0d_idle", v), int'(busy), 0);
    end

    // Stall: slot held by neuron 2, sweep waits at neuron 5.
    do_reset();
    write_cur(2, 12);
    write_cur(5, 12);
    spike_ready = 1'b1;
    run_sweep(n, gd);
    chk("stall_sweep1_events", n, 0);
    spike_ready = 1'b0;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) done_seen++;
      clk_step();
    end
    chk("stall_valid", int'(spike_valid), 1);
    chk("stall_idx", int'(spike_idx), 2);
    chk("stall_busy", int'(busy), 1);
    chk("stall_no_done", done_seen, 0);
    chk("stall_at_5", int'(dut.r_idx), 5);
    spike_ready = 1'b1;
    collect(n, gd);
    chk("stall_events", n, 2);
    chk("stall_ev0", ev[0], 2);
    chk("stall_ev1", ev[1], 5);
    chk("stall_done", gd, 1);

    // Overrun: a second tick during a sweep is ignored but flagged.
    do_reset();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    clk_step();
    clk_step();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    collect(n, gd);
    chk("ovr_done", gd, 1);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy || done) done_seen++;
      clk_step();
    end
    chk("ovr_no_second_sweep", done_seen, 0);
    chk("ovr_sticky", int'(overrun), 1);
    do_reset();
    chk("ovr_cleared", int'(overrun), 0);

    // Reset in the middle of a sweep with an event pending.
    do_reset();
    write_cur(0, 10);
    spike_ready = 1'b1;
    run_sweep(n, gd);
    spike_ready = 1'b0;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    clk_step();
    chk("mid_valid_before", int'(spike_valid), 1);
    reset = 1'b0;
    clk_step();
    chk("mid_valid", int'(spike_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_idx", int'(spike_idx), 0);
    chk("mid_state0", int'(dut.r_state[0]), 0);
    reset = 1'b1;
    spike_ready = 1'b1;

    // Config write in the cycle neuron 4 updates: the old current is used.
    do_reset();
    write_cur(4, 3);
    write_thr(31);
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    for (int k = 0; k < 4; k++) clk_step();
    chk("cfgw_idx4", int'(dut.r_idx), 4);
    write_cur(4, 20);
    collect(n, gd);
    chk("cfgw_state_old", int'(dut.r_state[4]), 3);
    run_sweep(n, gd);
    chk("cfgw_state_new", int'(dut.r_state[4]), 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
